// File: rtl/regfile_port_ctrl_pkg.sv
// rtl/regfile_port_ctrl_pkg.sv - shared constants and FSM encoding for the register-file port sequencer
// Purpose: register-file geometry (NREGS, AW, DW) and the sequencer state encoding.
// Ports: none (package).
package regfile_pkg;

  localparam int NREGS = 16;  // registers; one ld/oeA/oeB bit each
  localparam int AW    = 4;   // address width, log2(NREGS)
  localparam int DW    = 16;  // data width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// rtl/regfile_port_ctrl_if.sv - request, register-file and operand signals of the port sequencer
// Purpose: bundles the request handshake, register-file strobes/buses and operand output.
// Modports:
//   master - control unit / register file side (drives requests, DA_in/DB_in, rd_ready)
//   slave  - the sequencer (drives req_ready, ld/oeA/oeB, W_bus, rd_valid, S_out/T_out)
interface regfile_port_ctrl_if;
  import regfile_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             wr_en;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic [AW-1:0]    s_addr;
  logic [AW-1:0]    t_addr;
  logic [NREGS-1:0] ld;
  logic [NREGS-1:0] oeA;
  logic [NREGS-1:0] oeB;
  logic [DW-1:0]    W_bus;
  logic [DW-1:0]    DA_in;
  logic [DW-1:0]    DB_in;
  logic             rd_valid;
  logic             rd_ready;
  logic [DW-1:0]    S_out;
  logic [DW-1:0]    T_out;

  modport master (
    output req_valid, wr_en, w_addr, w_data, s_addr, t_addr, DA_in, DB_in, rd_ready,
    input  req_ready, ld, oeA, oeB, W_bus, rd_valid, S_out, T_out
  );

  modport slave (
    input  req_valid, wr_en, w_addr, w_data, s_addr, t_addr, DA_in, DB_in, rd_ready,
    output req_ready, ld, oeA, oeB, W_bus, rd_valid, S_out, T_out
  );

endinterface

// File: rtl/regfile_port_ctrl_addr_decode.sv
// rtl/regfile_port_ctrl_addr_decode.sv - enabled binary-to-one-hot register index decoder
// Purpose: turns a register index into a one-hot strobe vector, all-zero when disabled.
// Ports:
//   addr   in  AW     register index
//   en     in  1      strobe enable
//   onehot out NREGS  one-hot strobe (zero when en=0)
module addr_decode
  import regfile_pkg::*;
(
  input  logic [AW-1:0]    addr,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// rtl/regfile_port_ctrl.sv - write-then-dual-read sequencer for the 16 x 16-bit register file
// Purpose: accepts one operand-fetch request at a time (optional write, then read of S and T),
//          drives register load/output enables and the write bus, and holds captured operands.
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous active-low reset
//   bus    slave modport of regfile_port_ctrl_if (request, register-file strobes, operands)
module regfile_port_ctrl
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  regfile_port_ctrl_if.slave bus
);

  state_t        state_q, state_d;
  logic [AW-1:0] w_addr_q, s_addr_q, t_addr_q;
  logic [DW-1:0] w_data_q;
  logic [DW-1:0] s_q, t_q;

  logic [NREGS-1:0] ld_vec, oea_vec, oeb_vec;

  // The request's wr_en is consumed by the IDLE transition itself (WRITE vs READ),
  // so it needs no separate holding register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      w_addr_q <= '0;
      w_data_q <= '0;
      s_addr_q <= '0;
      t_addr_q <= '0;
      s_q      <= '0;
      t_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid) begin
        w_addr_q <= bus.w_addr;
        w_data_q <= bus.w_data;
        s_addr_q <= bus.s_addr;
        t_addr_q <= bus.t_addr;
      end
      if (state_q == READ) begin
        s_q <= bus.DA_in;
        t_q <= bus.DB_in;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rd_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = bus.wr_en ? WRITE : READ;
      end
      WRITE: state_d = READ;
      READ:  state_d = HOLD;
      HOLD: begin
        bus.rd_valid = 1'b1;
        if (bus.rd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes come only from state and latched indices, so input churn after
  // acceptance cannot disturb them.
  addr_decode u_ld_dec  (.addr(w_addr_q), .en(state_q == WRITE), .onehot(ld_vec));
  addr_decode u_oea_dec (.addr(s_addr_q), .en(state_q == READ),  .onehot(oea_vec));
  addr_decode u_oeb_dec (.addr(t_addr_q), .en(state_q == READ),  .onehot(oeb_vec));

  assign bus.ld    = ld_vec;
  assign bus.oeA   = oea_vec;
  assign bus.oeB   = oeb_vec;
  assign bus.W_bus = (state_q == WRITE) ? w_data_q : '0;
  assign bus.S_out = s_q;
  assign bus.T_out = t_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb/tb_regfile_port_ctrl.sv - self-checking bench for regfile_port_ctrl with a register-file model
module tb_regfile_port_ctrl;

  logic clk;
  logic reset;
  logic rf_init;
  logic [15:0] rf [16];

  int n_checks = 0;
  int n_fail   = 0;

  regfile_port_ctrl_if bus ();

  regfile_port_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: known preload, loads W_bus on ld, drives buses from oeA/oeB.
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (rf_init) begin
        case (i)
          0:       rf[i] <= 16'h0000;
          2:       rf[i] <= 16'h2222;
          7:       rf[i] <= 16'h7777;
          15:      rf[i] <= 16'h1234;
          default: rf[i] <= {12'hA00, 4'(i)};
        endcase
      end else if (bus.ld[i]) begin
        rf[i] <= bus.W_bus;
      end
    end
  end

  always_comb begin
    logic [15:0] da, db;
    da = '0;
    db = '0;
    for (int i = 0; i < 16; i++) begin
      if (bus.oeA[i]) da = da | rf[i];
      if (bus.oeB[i]) db = db | rf[i];
    end
    bus.DA_in = da;
    bus.DB_in = db;
  end

  typedef struct {
    logic        wr_en;
    logic [3:0]  w_addr;
    logic [15:0] w_data;
    logic [3:0]  s_addr;
    logic [3:0]  t_addr;
    logic [3:0]  churn_s;
    logic [15:0] exp_ld;
    logic [15:0] exp_oea;
    logic [15:0] exp_oeb;
    logic [15:0] exp_s;
    logic [15:0] exp_t;
  } vec_t;

  vec_t vecs [5];
  vec_t v_bp, v_rh, v_rw, v_fin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for req_ready, presents the request for one accepting edge,
  // then scrambles every request input to prove they are ignored after acceptance.
  task automatic issue(input vec_t v);
    for (int k = 0; k < 10 && !bus.req_ready; k++) @(negedge clk);
    chk("req_ready_before_issue", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.wr_en     = v.wr_en;
    bus.w_addr    = v.w_addr;
    bus.w_data    = v.w_data;
    bus.s_addr    = v.s_addr;
    bus.t_addr    = v.t_addr;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.wr_en     = ~v.wr_en;
    bus.w_addr    = ~v.w_addr;
    bus.w_data    = ~v.w_data;
    bus.s_addr    = v.churn_s;
    bus.t_addr    = ~v.t_addr;
  endtask

  // Checks each cycle after the accepting edge up to and including the first HOLD cycle.
  task automatic track(input vec_t v);
    int lat;
    lat = v.wr_en ? 3 : 2;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      chk("rd_valid_timing", bus.rd_valid, (n == lat) ? 1 : 0);
      chk("req_ready_busy", bus.req_ready, 0);
      if (v.wr_en && n == 1) begin
        chk("ld_write", bus.ld, v.exp_ld);
        chk("W_bus_write", bus.W_bus, v.w_data);
        chk("oeA_in_write", bus.oeA, 0);
        chk("oeB_in_write", bus.oeB, 0);
      end else if (n == lat - 1) begin
        chk("oeA_read", bus.oeA, v.exp_oea);
        chk("oeB_read", bus.oeB, v.exp_oeb);
        chk("ld_in_read", bus.ld, 0);
        chk("W_bus_in_read", bus.W_bus, 0);
      end else begin
        chk("ld_in_hold", bus.ld, 0);
        chk("oeA_in_hold", bus.oeA, 0);
        chk("oeB_in_hold", bus.oeB, 0);
        chk("W_bus_in_hold", bus.W_bus, 0);
        chk("S_out", bus.S_out, v.exp_s);
        chk("T_out", bus.T_out, v.exp_t);
      end
    end
  endtask

  task automatic release_hold(input vec_t v);
    bus.rd_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_ready = 1'b0;
    chk("rd_valid_after_release", bus.rd_valid, 0);
    chk("req_ready_after_release", bus.req_ready, 1);
    chk("S_out_kept", bus.S_out, v.exp_s);
    chk("T_out_kept", bus.T_out, v.exp_t);
  endtask

  task automatic chk_reset_state();
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_ld", bus.ld, 0);
    chk("rst_oeA", bus.oeA, 0);
    chk("rst_oeB", bus.oeB, 0);
    chk("rst_W_bus", bus.W_bus, 0);
    chk("rst_S_out", bus.S_out, 16'h0000);
    chk("rst_T_out", bus.T_out, 16'h0000);
    chk("rst_req_ready", bus.req_ready, 1);
  endtask

  initial begin
    //          wr    wa     wdata     sa     ta    churn   ld        oeA       oeB       S         T
    vecs[0] = '{1'b1, 4'd3,  16'hBEEF, 4'd3,  4'd0,  4'd9, 16'h0008, 16'h0008, 16'h0001, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 4'd6,  16'hDEAD, 4'd15, 4'd15, 4'd1, 16'h0000, 16'h8000, 16'h8000, 16'h1234, 16'h1234};
    vecs[2] = '{1'b1, 4'd10, 16'h5A5A, 4'd0,  4'd10, 4'd4, 16'h0400, 16'h0001, 16'h0400, 16'h0000, 16'h5A5A};
    vecs[3] = '{1'b0, 4'd0,  16'h0000, 4'd7,  4'd3,  4'd2, 16'h0000, 16'h0080, 16'h0008, 16'h7777, 16'hBEEF};
    vecs[4] = '{1'b0, 4'd0,  16'h0000, 4'd2,  4'd15, 4'd7, 16'h0000, 16'h0004, 16'h8000, 16'h2222, 16'h1234};
    v_bp    = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd3,  4'd0, 16'h0000, 16'h8000, 16'h0008, 16'h1234, 16'hBEEF};
    v_rh    = '{1'b0, 4'd0,  16'h0000, 4'd2,  4'd7,  4'd5, 16'h0000, 16'h0004, 16'h0080, 16'h2222, 16'h7777};
    v_rw    = '{1'b1, 4'd5,  16'h1111, 4'd5,  4'd5,  4'd6, 16'h0020, 16'h0020, 16'h0020, 16'h1111, 16'h1111};
    v_fin   = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd3,  4'd8, 16'h0000, 16'h0008, 16'h0008, 16'hBEEF, 16'hBEEF};

    reset         = 1'b0;
    rf_init       = 1'b1;
    bus.req_valid = 1'b0;
    bus.wr_en     = 1'b0;
    bus.w_addr    = '0;
    bus.w_data    = '0;
    bus.s_addr    = '0;
    bus.t_addr    = '0;
    bus.rd_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    reset   = 1'b1;
    rf_init = 1'b0;

    for (int i = 0; i < 5; i++) begin
      issue(vecs[i]);
      track(vecs[i]);
      release_hold(vecs[i]);
    end

    // Backpressure: a competing request must not be taken while HOLD is stalled.
    issue(v_bp);
    track(v_bp);
    bus.req_valid = 1'b1;
    bus.wr_en     = 1'b1;
    bus.w_addr    = 4'd1;
    bus.w_data    = 16'hFFFF;
    bus.s_addr    = 4'd1;
    bus.t_addr    = 4'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rd_valid", bus.rd_valid, 1);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_S_out", bus.S_out, v_bp.exp_s);
      chk("bp_T_out", bus.T_out, v_bp.exp_t);
      chk("bp_ld", bus.ld, 0);
    end
    bus.req_valid = 1'b0;
    release_hold(v_bp);
    @(negedge clk);
    chk("bp_no_accept_ld", bus.ld, 0);
    chk("bp_idle_req_ready", bus.req_ready, 1);

    // Reset held for two cycles while in HOLD.
    issue(v_rh);
    track(v_rh);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state();
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rh_rd_valid_2", bus.rd_valid, 0);
    chk("rh_req_ready_2", bus.req_ready, 1);

    // Reset landing on the WRITE closing edge.
    issue(v_rw);
    @(negedge clk);
    chk("rw_ld_pulse", bus.ld, v_rw.exp_ld);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rw_ld_ended", bus.ld, 0);
    chk("rw_W_bus", bus.W_bus, 0);
    chk("rw_req_ready", bus.req_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rw_no_rd_valid", bus.rd_valid, 0);
      chk("rw_no_read_oeA", bus.oeA, 0);
      chk("rw_no_ld", bus.ld, 0);
    end

    issue(v_fin);
    track(v_fin);
    release_hold(v_fin);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
- Sequencer that owns the write and read ends of the 16 x 16-bit register file built from reg16 instances.
- Accepts one operand-fetch request at a time: an optional write, then a dual read of S and T.
- Drives the per-register load and output-enable vectors and the shared write-data bus. Captures the shared A/B read buses into held operand registers.
- Sits between the control unit and the register file.

Parameters:
NREGS, 16, number of registers; one ld/oeA/oeB bit each
AW, 4, address width; log2(NREGS)
DW, 16, data width

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-low reset (reset==0 at posedge resets)
req_valid  input  1  request present
req_ready  output  1  block can accept a request
wr_en  input  1  request includes a write
w_addr  input  AW  write register index
w_data  input  DW  write data
s_addr  input  AW  register index read onto bus A
t_addr  input  AW  register index read onto bus B
ld  output  NREGS  one-hot register load enables
oeA  output  NREGS  one-hot bus-A output enables
oeB  output  NREGS  one-hot bus-B output enables
W_bus  output  DW  data to all register Din inputs
DA_in  input  DW  shared bus A from the register file
DB_in  input  DW  shared bus B from the register file
rd_valid  output  1  S_out/T_out valid
rd_ready  input  1  consumer accepts operands
S_out  output  DW  captured bus-A value
T_out  output  DW  captured bus-B value

Behaviour:
- Reset: at a posedge with reset==0, the block:
  - goes to IDLE and clears all latched addresses and w_data;
  - clears S_out and T_out to 16'h0000;
  - sets ld, oeA, oeB and W_bus to 0 and rd_valid to 0.
  - req_ready is 1 in IDLE.
  - Reset mid-operation aborts the request with no further ld pulse and no captured data.
- FSM states: IDLE, WRITE, READ, HOLD.
- IDLE: req_ready=1.
  - On posedge with req_valid=1, latch wr_en, w_addr, w_data, s_addr, t_addr.
  - Go to WRITE if wr_en=1, else to READ.
- WRITE (1 cycle):
  - ld = 1<<w_addr and W_bus = latched w_data; the register loads at the closing edge.
  - Always go to READ.
- READ (1 cycle):
  - oeA = 1<<s_addr and oeB = 1<<t_addr.
  - At the closing edge, S_out<=DA_in, T_out<=DB_in, then go to HOLD.
- HOLD: rd_valid=1 and S_out/T_out are stable.
  - On posedge with rd_ready=1, go to IDLE and drop rd_valid.
  - S_out/T_out keep their last values until the next READ capture.
- req_ready=0 in WRITE, READ and HOLD. No request overlap.
- Decoded outputs:
  - ld, oeA and oeB are decoded only from state and latched addresses, never from live inputs.
  - They are all-zero outside their own state.
  - At most one bit of each vector is high.
- W_bus is 0 outside WRITE.
- Latency from the accepting edge to rd_valid=1: 2 cycles with no write, 3 cycles with a write.
- Read-after-write: when s_addr or t_addr equals w_addr, the captured value is the new w_data, because WRITE completes before READ.
- s_addr==t_addr is legal: the same register drives both buses and S_out==T_out.
- No tri-state inside the block. DA_in/DB_in are sampled only in READ.
- Inputs are ignored outside IDLE; changes to them after acceptance have no effect.

Decomposition:
- Shared package regfile_pkg holds:
  - state encoding (IDLE=2'd0, WRITE=2'd1, READ=2'd2, HOLD=2'd3);
  - constants NREGS, AW, DW.
- One sub-module, addr_decode (AW-in, NREGS-bit one-hot out, with an enable), instantiated three times for ld, oeA and oeB.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-HOLD. Required after the reset edge:
  - rd_valid=0, ld=oeA=oeB=0, S_out=T_out=16'h0000, req_ready=1.
- Write then read, same register: req wr_en=1, w_addr=3, w_data=16'hBEEF, s_addr=3, t_addr=0, register-file model R0=16'h0000. Required:
  - ld=16'h0008 for exactly 1 cycle with W_bus=16'hBEEF;
  - then oeA=16'h0008 and oeB=16'h0001;
  - rd_valid at accept+3, S_out=16'hBEEF, T_out=16'h0000.
- Read only: wr_en=0, s_addr=15, t_addr=15 with R15=16'h1234. Required:
  - ld never asserted, oeA=oeB=16'h8000;
  - rd_valid at accept+2, S_out=T_out=16'h1234.
- Backpressure: hold rd_ready=0 for 5 cycles in HOLD. Required:
  - rd_valid stays 1 and S_out/T_out stay stable;
  - req_ready=0 and a new req_valid is not accepted;
  - rd_ready=1 then returns to IDLE on the next edge.
- Reset during WRITE: assert reset=0 at the WRITE closing edge. Required:
  - the ld pulse ends at that edge;
  - no READ, rd_valid stays 0, and the next request is accepted normally.
- Input churn: change s_addr to 7 one cycle after accepting s_addr=2. Required:
  - oeA=16'h0004 and S_out equals R2.
